// File: rtl/traffic_scheduler_if.sv
// Signal bundle between the game-flow scheduler and the button/collision and car-rendering logic.
// The master side is the scheduler; the slave side drives start/pause/crash/ack.
interface traffic_scheduler_if;
    logic        start_game;
    logic        pause;
    logic        crash;
    logic        spawn_ack;
    logic        spawn_req;
    logic [1:0]  spawn_lane;
    logic [19:0] speed;
    logic [7:0]  level;
    logic [1:0]  state;
    logic        game_over;

    modport master (
        input  start_game, pause, crash, spawn_ack,
        output spawn_req, spawn_lane, speed, level, state, game_over
    );

    modport slave (
        output start_game, pause, crash, spawn_ack,
        input  spawn_req, spawn_lane, speed, level, state, game_over
    );
endinterface

// File: rtl/traffic_scheduler.sv
// Game-flow controller: sequences IDLE/RUN/PAUSED/OVER, issues one car-spawn request per
// period over a req/ack handshake, and shortens the period every SPAWNS_PER_LEVEL accepted spawns.
module traffic_scheduler #(
    parameter int          LANES            = 3,
    parameter logic [19:0] SPEED_INIT       = 20'd10000,
    parameter logic [19:0] SPEED_STEP       = 20'd100,
    parameter logic [19:0] SPEED_MIN        = 20'd2000,
    parameter logic [7:0]  SPAWNS_PER_LEVEL = 8'd10
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    traffic_scheduler_if.master   bus_io
);
    localparam logic [1:0]  ST_IDLE    = 2'b00;
    localparam logic [1:0]  ST_RUN     = 2'b01;
    localparam logic [1:0]  ST_PAUSED  = 2'b10;
    localparam logic [1:0]  ST_OVER    = 2'b11;
    localparam logic [7:0]  LANES_W    = 8'(LANES);
    localparam logic [20:0] STEP_FLOOR = {1'b0, SPEED_MIN} + {1'b0, SPEED_STEP};

    logic [1:0]  state_q, state_d;
    logic [19:0] speed_q, speed_d;
    logic [7:0]  level_q, level_d;
    logic [19:0] cnt_q, cnt_d;
    logic [7:0]  scnt_q, scnt_d;
    logic [7:0]  lfsr_q, lfsr_d;
    logic        req_q, req_d;
    logic [1:0]  lane_q, lane_d;
    logic        over_q, over_d;
    logic        accept;
    logic        expiry;

    always_comb begin
        lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        state_d = state_q;
        speed_d = speed_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        scnt_d  = scnt_q;
        req_d   = req_q;
        lane_d  = lane_q;
        accept  = req_q & bus_io.spawn_ack;
        expiry  = ({1'b0, cnt_q} + 21'd1) >= {1'b0, speed_q};

        case (state_q)
            ST_IDLE: begin
                speed_d = SPEED_INIT;
                level_d = 8'd0;
                cnt_d   = 20'd0;
                scnt_d  = 8'd0;
                req_d   = 1'b0;
                if (bus_io.start_game) state_d = ST_RUN;
            end
            ST_RUN, ST_PAUSED: begin
                if (bus_io.crash) begin
                    state_d = ST_OVER;
                    req_d   = 1'b0;
                end else begin
                    if (state_q == ST_RUN && bus_io.pause)
                        state_d = ST_PAUSED;
                    else if (state_q == ST_PAUSED && !bus_io.pause)
                        state_d = ST_RUN;

                    if (accept) begin
                        req_d = 1'b0;
                        if (scnt_q + 8'd1 == SPAWNS_PER_LEVEL) begin
                            scnt_d = 8'd0;
                            if (level_q != 8'hFF) level_d = level_q + 8'd1;
                            speed_d = ({1'b0, speed_q} >= STEP_FLOOR) ? speed_q - SPEED_STEP
                                                                      : SPEED_MIN;
                        end else begin
                            scnt_d = scnt_q + 8'd1;
                        end
                    end

                    // Counting follows the pause input, so the resume cycle already counts.
                    if (!bus_io.pause) begin
                        if (expiry) begin
                            cnt_d = 20'd0;
                            if (!req_q) begin
                                req_d  = 1'b1;
                                lane_d = 2'(lfsr_q % LANES_W);
                            end
                        end else begin
                            cnt_d = cnt_q + 20'd1;
                        end
                    end
                end
            end
            default: begin
                req_d = 1'b0;
                if (!bus_io.start_game) begin
                    state_d = ST_IDLE;
                    speed_d = SPEED_INIT;
                    level_d = 8'd0;
                    cnt_d   = 20'd0;
                    scnt_d  = 8'd0;
                end
            end
        endcase

        over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            speed_q <= SPEED_INIT;
            level_q <= 8'd0;
            cnt_q   <= 20'd0;
            scnt_q  <= 8'd0;
            lfsr_q  <= 8'hA5;
            req_q   <= 1'b0;
            lane_q  <= 2'd0;
            over_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            speed_q <= speed_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            scnt_q  <= scnt_d;
            lfsr_q  <= lfsr_d;
            req_q   <= req_d;
            lane_q  <= lane_d;
            over_q  <= over_d;
        end
    end

    assign bus_io.spawn_req  = req_q;
    assign bus_io.spawn_lane = lane_q;
    assign bus_io.speed      = speed_q;
    assign bus_io.level      = level_q;
    assign bus_io.state      = state_q;
    assign bus_io.game_over  = over_q;
endmodule

// File: tb/tb_traffic_scheduler.sv
// Self-checking bench for traffic_scheduler: directed game scenarios plus a randomized phase,
// all compared every cycle against a behavioural model of the game rules.
module tb_traffic_scheduler;
    localparam int P_INIT = 20;
    localparam int P_STEP = 5;
    localparam int P_MIN  = 10;
    localparam int P_SPL  = 2;
    localparam int P_LANES = 3;

    logic clk;
    logic rst_n;
    traffic_scheduler_if bus();

    traffic_scheduler #(
        .LANES(P_LANES),
        .SPEED_INIT(20'd20),
        .SPEED_STEP(20'd5),
        .SPEED_MIN(20'd10),
        .SPAWNS_PER_LEVEL(8'd2)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .bus_io(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model of the game rules
    int m_state, m_speed, m_level, m_cnt, m_scnt, m_lfsr, m_req, m_lane, m_over;
    int m_accepts = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_speed = P_INIT; m_level = 0; m_cnt = 0; m_scnt = 0;
        m_lfsr = 'hA5; m_req = 0; m_lane = 0; m_over = 0;
    endtask

    task automatic model_step();
        int o_state, o_cnt, o_speed, o_req, o_lfsr;
        if (!rst_n) begin
            model_reset();
            return;
        end
        o_state = m_state; o_cnt = m_cnt; o_speed = m_speed; o_req = m_req; o_lfsr = m_lfsr;
        m_lfsr = ((o_lfsr * 2) % 256) + (((o_lfsr >> 7) ^ (o_lfsr >> 5) ^ (o_lfsr >> 4) ^ (o_lfsr >> 3)) & 1);
        if (o_state == 0) begin
            m_speed = P_INIT; m_level = 0; m_cnt = 0; m_scnt = 0; m_req = 0;
            if (bus.start_game) m_state = 1;
        end else if (o_state == 3) begin
            m_req = 0;
            if (!bus.start_game) begin
                m_state = 0; m_speed = P_INIT; m_level = 0; m_cnt = 0; m_scnt = 0;
            end
        end else if (bus.crash) begin
            m_state = 3;
            m_req = 0;
        end else begin
            if (o_state == 1 && bus.pause) m_state = 2;
            if (o_state == 2 && !bus.pause) m_state = 1;
            if (o_req == 1 && bus.spawn_ack) begin
                m_req = 0;
                m_accepts++;
                m_scnt++;
                if (m_scnt == P_SPL) begin
                    m_scnt = 0;
                    if (m_level < 255) m_level++;
                    m_speed = (o_speed - P_STEP < P_MIN) ? P_MIN : o_speed - P_STEP;
                end
            end
            if (!bus.pause) begin
                if (o_cnt >= o_speed - 1) begin
                    m_cnt = 0;
                    if (o_req == 0) begin
                        m_req = 1;
                        m_lane = o_lfsr % P_LANES;
                    end
                end else begin
                    m_cnt = o_cnt + 1;
                end
            end
        end
        m_over = (m_state == 3) ? 1 : 0;
    endtask

    task automatic check_all();
        chk("spawn_req", 32'(bus.spawn_req), m_req);
        chk("spawn_lane", 32'(bus.spawn_lane), m_lane);
        chk("speed", 32'(bus.speed), m_speed);
        chk("level", 32'(bus.level), m_level);
        chk("state", 32'(bus.state), m_state);
        chk("game_over", 32'(bus.game_over), m_over);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic wait_req(input int bound);
        int n = 0;
        while (bus.spawn_req !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        chk("wait_req_timeout", 32'(bus.spawn_req), 1);
    endtask

    initial begin
        int n;
        int last;
        logic [1:0] lane0;

        rst_n = 1'b0;
        bus.start_game = 1'b0;
        bus.pause = 1'b0;
        bus.crash = 1'b0;
        bus.spawn_ack = 1'b0;
        model_reset();

        // Reset values
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk("reset_speed", 32'(bus.speed), 20);

        // Start: RUN next edge, first request 20 cycles later
        bus.start_game = 1'b1;
        tick();
        chk("start_state", 32'(bus.state), 1);
        bus.start_game = 1'b0;
        n = 0;
        while (bus.spawn_req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("first_req_delay", n, 20);
        chk("lane_range", 32'(bus.spawn_lane < 2'd3), 1);
        $display("step start: first spawn after %0d cycles lane=%0d", n, bus.spawn_lane);

        // Ack withheld: request and lane hold, expiries dropped
        lane0 = bus.spawn_lane;
        repeat (50) tick();
        chk("hold_req", 32'(bus.spawn_req), 1);
        chk("hold_lane", 32'(bus.spawn_lane), 32'(lane0));
        chk("hold_level", 32'(bus.level), 0);
        bus.spawn_ack = 1'b1;
        tick();
        bus.spawn_ack = 1'b0;
        chk("ack_release", 32'(bus.spawn_req), 0);
        $display("step hold: released after 50 cycles, level=%0d", bus.level);

        // Immediate acks: level/speed every two accepts, floor at SPEED_MIN
        bus.spawn_ack = 1'b1;
        last = m_accepts;
        n = 0;
        while (last < 6 && n < 500) begin
            tick();
            n++;
            if (m_accepts != last) begin
                last = m_accepts;
                if (last == 2) begin
                    chk("lvl_after2", 32'(bus.level), 1);
                    chk("spd_after2", 32'(bus.speed), 15);
                end else if (last == 4) begin
                    chk("lvl_after4", 32'(bus.level), 2);
                    chk("spd_after4", 32'(bus.speed), 10);
                end else if (last == 6) begin
                    chk("lvl_after6", 32'(bus.level), 3);
                    chk("spd_after6", 32'(bus.speed), 10);
                end
                $display("step ack: accepts=%0d level=%0d speed=%0d", last, bus.level, bus.speed);
            end
        end
        chk("accepts_reached", last, 6);
        bus.spawn_ack = 1'b0;

        // Crash with pending request
        wait_req(100);
        bus.crash = 1'b1;
        bus.start_game = 1'b1;
        tick();
        bus.crash = 1'b0;
        chk("crash_req", 32'(bus.spawn_req), 0);
        chk("crash_state", 32'(bus.state), 3);
        chk("crash_over", 32'(bus.game_over), 1);
        chk("crash_level_hold", 32'(bus.level), 3);
        repeat (5) tick();
        chk("over_held", 32'(bus.state), 3);
        bus.start_game = 1'b0;
        tick();
        chk("idle_state", 32'(bus.state), 0);
        chk("idle_speed", 32'(bus.speed), 20);
        chk("idle_level", 32'(bus.level), 0);
        bus.start_game = 1'b1;
        tick();
        bus.start_game = 1'b0;
        chk("restart_state", 32'(bus.state), 1);
        $display("step crash: over then restart state=%0d", bus.state);

        // Pause 30 cycles from counter=10 delays the spawn by exactly 30
        n = 0;
        while (m_cnt != 10 && n < 50) begin
            tick();
            n++;
        end
        chk("cnt10_reached", m_cnt, 10);
        bus.pause = 1'b1;
        n = 0;
        repeat (30) begin
            tick();
            n++;
            if (n == 15) chk("paused_state", 32'(bus.state), 2);
        end
        bus.pause = 1'b0;
        while (bus.spawn_req !== 1'b1 && n < 80) begin
            tick();
            n++;
        end
        chk("pause_delay", n, 40);
        $display("step pause: spawn %0d cycles after counter=10", n);

        // Randomized play
        for (int i = 0; i < 1500; i++) begin
            bus.spawn_ack = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 39) == 0) bus.pause = ~bus.pause;
            bus.crash = ($urandom_range(0, 149) == 0);
            if ($urandom_range(0, 19) == 0) bus.start_game = ~bus.start_game;
            tick();
        end
        $display("step random: 1500 cycles, accepts=%0d level=%0d", m_accepts, bus.level);

        // Asynchronous reset mid-RUN with a pending request
        bus.crash = 1'b0;
        bus.pause = 1'b0;
        bus.spawn_ack = 1'b0;
        bus.start_game = 1'b0;
        repeat (2) tick();
        bus.start_game = 1'b1;
        wait_req(200);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_req", 32'(bus.spawn_req), 0);
        $display("step async reset: state=%0d req=%0d", bus.state, bus.spawn_req);
        repeat (2) tick();
        rst_n = 1'b1;
        bus.start_game = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/traffic_scheduler.md
# traffic_scheduler

Game-flow controller for Lane Splitter's incoming-car datapath: owns the spawn-period (speed) register, sequences game states, and issues one car-spawn request per period to the car/display datapath over a req/ack handshake. It raises difficulty by shortening the period every N accepted spawns and picks the lane with an LFSR. It sits between the button/collision logic and the car-rendering datapath.

## Interface
- LANES, 3, number of lanes (2..4)
- SPEED_INIT, 20'd10000, spawn period in clk cycles at level 0
- SPEED_STEP, 20'd100, period decrement per level
- SPEED_MIN, 20'd2000, period floor (must be ≥1)
- SPAWNS_PER_LEVEL, 8'd10, accepted spawns per level-up
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- start_game  in  1  level-sensitive start request
- pause  in  1  freeze period counting while high
- crash  in  1  collision pulse from collision logic
- spawn_ack  in  1  datapath accepted current spawn
- spawn_req  out  1  spawn request
- spawn_lane  out  2  lane for current request, 0..LANES-1
- speed  out  20  current spawn period in cycles
- level  out  8  difficulty level
- state  out  2  00 IDLE, 01 RUN, 10 PAUSED, 11 OVER
- game_over  out  1  high exactly while state==OVER

## Operation
- All outputs registered. Reset (rst=0, async): state IDLE, speed=SPEED_INIT, level=0, spawn_req=0, spawn_lane=0, game_over=0, period counter=0, spawn count=0, LFSR=8'hA5.
- IDLE: speed=SPEED_INIT, level=0, counters 0, spawn_req=0. start_game=1 → RUN.
- RUN: 20-bit period counter increments each cycle; when counter ≥ speed−1 ("expiry") counter→0 and, if spawn_req=0, spawn_req→1 with spawn_lane←lfsr % LANES. Expiry while spawn_req=1: spawn dropped, no queuing, counter still restarts.
- Handshake: spawn_req held high and spawn_lane held stable until a cycle with spawn_req&spawn_ack; spawn_req→0 next cycle. spawn_ack with spawn_req=0 ignored.
- Each accepted spawn: spawn count+1; on reaching SPAWNS_PER_LEVEL → count 0, level+1 (saturate 255), speed←max(speed−SPEED_STEP, SPEED_MIN) (no underflow; compare before subtract).
- pause=1 in RUN → PAUSED; pause=0 in PAUSED → RUN. In PAUSED the counter freezes; pending spawn_req stays high and can still be acked (level/speed update as in RUN).
- crash=1 in RUN or PAUSED → OVER; spawn_req forced 0 the next cycle (request aborted, not counted); game_over=1. speed/level hold their values in OVER.
- OVER → IDLE only when start_game=0 (start must be re-pressed); IDLE then restores SPEED_INIT/level 0.
- Priority in the same cycle: crash > pause > expiry/handshake. Ack coincident with crash: spawn not counted.
- LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, shifts every cycle in all states; never zero.

## Timing
- start_game sampled high in IDLE at edge k → state=RUN after edge k, counter=0; first spawn_req visible after edge k+speed.
- Subsequent expiries every speed cycles while RUN, independent of ack timing (unless dropped).
- Ack accepted at edge j → spawn_req=0, level/speed updated after edge j; new speed applies to the current period (≥ compare handles counter already past new limit: expires next cycle).
- State transitions take one edge; game_over tracks state with no extra lag.

## Test plan
- Params SPEED_INIT=20, SPEED_STEP=5, SPEED_MIN=10, SPAWNS_PER_LEVEL=2. Reset → all reset values; start_game=1 → state=01 next edge, spawn_req rises 20 cycles later, spawn_lane ∈ {0,1,2}.
- Ack held low 50 cycles → spawn_req stays 1, spawn_lane constant, two expiries dropped, level=0; 1-cycle ack → spawn_req=0 next cycle.
- Immediate acks → after 2 accepts level=1 speed=15, after 4 level=2 speed=10, after 6 level=3 speed=10 (floor).
- pause high for 30 cycles starting at counter=10 → state=10 during pause; next spawn_req exactly 30 cycles later than unpaused run.
- crash while spawn_req=1 → spawn_req=0, state=11, game_over=1; start_game held 1 keeps OVER; start_game=0 → IDLE, speed=20, level=0; start_game=1 → RUN.
- rst low asynchronously mid-RUN with spawn_req=1 → all outputs at reset values before next clk edge.
